// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Holds the active-low segment patterns (bit 0 = a ... bit 6 = g) and a
// helper that sizes the prescaler counter from the slot length.
// No ports; imported by seg7_glyph_rom and seg7_scan_controller.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_A    = 7'b0001000;
    localparam logic [6:0] SEG_B    = 7'b0000011;
    localparam logic [6:0] SEG_C    = 7'b1000110;
    localparam logic [6:0] SEG_D    = 7'b0100001;
    localparam logic [6:0] SEG_E    = 7'b0000110;
    localparam logic [6:0] SEG_F    = 7'b0001110;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Bits needed to count 0..div-1; never narrower than one bit.
    function automatic int prescWidth(input int div);
        int w;
        w = $clog2(div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Nibble to seven-segment glyph decoder (active-low, bit 0 = a).
// Ports:
//   nibble_i  - 4-bit code to display
//   hexMode_i - 1: codes 10-15 render as A,b,C,d,E,F; 0: they render as a dash
//   seg_o     - active-low segment pattern
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       hexMode_i,
    output logic [6:0] seg_o
);

    // Pure lookup; codes above 9 fall back to a dash outside hex mode.
    always_comb begin
        seg_o = SEG_DASH;
        case (nibble_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = hexMode_i ? SEG_A : SEG_DASH;
            4'hB: seg_o = hexMode_i ? SEG_B : SEG_DASH;
            4'hC: seg_o = hexMode_i ? SEG_C : SEG_DASH;
            4'hD: seg_o = hexMode_i ? SEG_D : SEG_DASH;
            4'hE: seg_o = hexMode_i ? SEG_E : SEG_DASH;
            4'hF: seg_o = hexMode_i ? SEG_F : SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// A load strobe captures a packed nibble word plus decimal points into a
// pending buffer; the buffer is copied into the displayed shadow copy only
// when the digit index wraps, so a frame never mixes old and new digits.
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   enable      - 1 scans; 0 darkens all anodes and freezes the scan position
//   blank_lz    - 1 blanks leading zero digits (digit 0 is always shown)
//   load        - one-cycle strobe capturing value/dp
//   value, dp   - packed nibbles (digit 0 rightmost) and per-digit points
//   seg, dp_n   - active-low segments and decimal point
//   an          - active-low anodes, one low at a time while scanning
//   frame_done  - one-cycle pulse after the index wraps back to digit 0
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 100000,
    parameter int HEX_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    blank_lz,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PW = prescWidth(CLK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           prescale_q, prescale_d;
    logic [IW-1:0]           digitIdx_q, digitIdx_d;
    logic [4*NUM_DIGITS-1:0] pendingValue_q, pendingValue_d;
    logic [NUM_DIGITS-1:0]   pendingDp_q, pendingDp_d;
    logic                    pendingFlag_q, pendingFlag_d;
    logic [4*NUM_DIGITS-1:0] shadowValue_q, shadowValue_d;
    logic [NUM_DIGITS-1:0]   shadowDp_q, shadowDp_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dpN_q, dpN_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frameDone_q, frameDone_d;

    logic       tick;
    logic       wrap;
    logic [3:0] curNibble;
    logic       curDp;
    logic       curBlank;
    logic [6:0] glyph;

    // A disabled scanner never reaches terminal count, so it can never wrap.
    assign tick = enable && (prescale_q == PRESC_LAST);
    assign wrap = tick && (digitIdx_q == IDX_LAST);

    // Scan position: slot prescaler and digit index, both frozen while disabled.
    always_comb begin
        prescale_d = prescale_q;
        digitIdx_d = digitIdx_q;
        if (enable) begin
            if (tick) begin
                prescale_d = '0;
                digitIdx_d = (digitIdx_q == IDX_LAST) ? '0 : digitIdx_q + IW'(1);
            end else begin
                prescale_d = prescale_q + PW'(1);
            end
        end
    end

    // Double buffering. A load coinciding with the wrap goes straight to the
    // shadow so it is shown in the frame that starts now, not one frame later.
    always_comb begin
        pendingValue_d = pendingValue_q;
        pendingDp_d    = pendingDp_q;
        pendingFlag_d  = pendingFlag_q;
        shadowValue_d  = shadowValue_q;
        shadowDp_d     = shadowDp_q;
        if (load) begin
            pendingValue_d = value;
            pendingDp_d    = dp;
            pendingFlag_d  = 1'b1;
        end
        if (wrap) begin
            pendingFlag_d = 1'b0;
            if (load) begin
                shadowValue_d = value;
                shadowDp_d    = dp;
            end else if (pendingFlag_q) begin
                shadowValue_d = pendingValue_q;
                shadowDp_d    = pendingDp_q;
            end
        end
    end

    // Select the current digit from the shadow and decide whether it is a
    // leading zero: blanked only if it and every more significant nibble is 0.
    always_comb begin
        curNibble = '0;
        curDp     = 1'b0;
        curBlank  = blank_lz && (digitIdx_q != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digitIdx_q == IW'(i)) begin
                curNibble = shadowValue_q[4*i +: 4];
                curDp     = shadowDp_q[i];
            end
            if ((IW'(i) >= digitIdx_q) && (shadowValue_q[4*i +: 4] != 4'h0)) begin
                curBlank = 1'b0;
            end
        end
    end

    seg7_glyph_rom uGlyph (
        .nibble_i  (curNibble),
        .hexMode_i (HEX_MODE != 0),
        .seg_o     (glyph)
    );

    // Next output values, registered so the pins lag the index by one cycle.
    always_comb begin
        an_d        = '1;
        seg_d       = SEG_OFF;
        dpN_d       = 1'b1;
        frameDone_d = wrap;
        if (enable && !curBlank) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (digitIdx_q == IW'(i)) begin
                    an_d[i] = 1'b0;
                end
            end
            seg_d = glyph;
            dpN_d = ~curDp;
        end
    end

    // All state, cleared together by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescale_q     <= '0;
            digitIdx_q     <= '0;
            pendingValue_q <= '0;
            pendingDp_q    <= '0;
            pendingFlag_q  <= 1'b0;
            shadowValue_q  <= '0;
            shadowDp_q     <= '0;
            seg_q          <= SEG_OFF;
            dpN_q          <= 1'b1;
            an_q           <= '1;
            frameDone_q    <= 1'b0;
        end else begin
            prescale_q     <= prescale_d;
            digitIdx_q     <= digitIdx_d;
            pendingValue_q <= pendingValue_d;
            pendingDp_q    <= pendingDp_d;
            pendingFlag_q  <= pendingFlag_d;
            shadowValue_q  <= shadowValue_d;
            shadowDp_q     <= shadowDp_d;
            seg_q          <= seg_d;
            dpN_q          <= dpN_d;
            an_q           <= an_d;
            frameDone_q    <= frameDone_d;
        end
    end

    assign seg        = seg_q;
    assign dp_n       = dpN_q;
    assign an         = an_q;
    assign frame_done = frameDone_q;

endmodule
